fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer.sv | 125 ++++++++++++
 tb/tb_fetch_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch / program-counter sequencer for the TB4004 core: eight-phase
// cycle generation, nibble-wide ROM addressing, opcode capture and control transfers.
module fetch_sequencer (
  input  logic        clk,
  input  logic        rstN,
  input  logic        stepEn,
  input  logic [3:0]  dataIn,
  input  logic        ccIn,
  input  logic        iszNotZero,
  input  logic [7:0]  pairData,
  output logic [2:0]  cycle,
  output logic        sync,
  output logic [3:0]  dataOut,
  output logic        dataOe,
  output logic [3:0]  opr,
  output logic [3:0]  opa,
  output logic        secondWord,
  output logic [7:0]  operand2,
  output logic [11:0] pc
);

  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} phase_t;

  phase_t      r_cycle;
  logic [11:0] r_pc;
  logic [3:0]  r_opr;
  logic [3:0]  r_opa;
  logic [7:0]  r_operand2;
  logic        r_second;
  logic [11:0] r_stack [3];
  logic [1:0]  r_sp;

  logic        w_isFin;
  logic        w_isJin;
  logic        w_twoWord;
  logic [1:0]  w_spInc;
  logic [1:0]  w_spDec;
  logic [11:0] w_addr;

  assign w_isFin = (r_opr == 4'h3) && !r_opa[0];
  assign w_isJin = (r_opr == 4'h3) &&  r_opa[0];
  assign w_twoWord = (r_opr == 4'h1) || (r_opr == 4'h4) || (r_opr == 4'h5) ||
                     (r_opr == 4'h7) ||
                     (((r_opr == 4'h2) || (r_opr == 4'h3)) && !r_opa[0]);
  assign w_spInc = (r_sp == 2'd2) ? 2'd0 : r_sp + 2'd1;
  assign w_spDec = (r_sp == 2'd0) ? 2'd2 : r_sp - 2'd1;

  // r_pc already points past the current word by X3, so r_pc[11:8] is the "page".
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_cycle    <= A1;
      r_pc       <= '0;
      r_opr      <= '0;
      r_opa      <= '0;
      r_operand2 <= '0;
      r_second   <= 1'b0;
      r_sp       <= '0;
      for (int unsigned i = 0; i < 3; i++) r_stack[i] <= '0;
    end else if (stepEn) begin
      r_cycle <= phase_t'(r_cycle + 3'd1);
      unique case (r_cycle)
        M1: begin
          if (r_second) r_operand2[7:4] <= dataIn;
          else          r_opr           <= dataIn;
        end
        M2: begin
          if (r_second) begin
            r_operand2[3:0] <= dataIn;
            if (!w_isFin) r_pc <= r_pc + 12'd1;
          end else begin
            r_opa <= dataIn;
            r_pc  <= r_pc + 12'd1;
          end
        end
        X3: begin
          if (r_second) begin
            r_second <= 1'b0;
            case (r_opr)
              4'h1: if (ccIn) r_pc <= {r_pc[11:8], r_operand2};
              4'h4: r_pc <= {r_opa, r_operand2};
              4'h5: begin
                r_stack[r_sp] <= r_pc;
                r_sp          <= w_spInc;
                r_pc          <= {r_opa, r_operand2};
              end
              4'h7: if (iszNotZero) r_pc <= {r_pc[11:8], r_operand2};
              default: ;
            endcase
          end else begin
            r_second <= w_twoWord;
            if (w_isJin) begin
              r_pc <= {r_pc[11:8], pairData};
            end else if (r_opr == 4'hC) begin
              r_pc <= r_stack[w_spDec];
              r_sp <= w_spDec;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // FIN's data fetch borrows the address phases with the pair value as the low byte.
  always_comb begin
    w_addr  = (r_second && w_isFin) ? {r_pc[11:8], pairData} : r_pc;
    dataOut = '0;
    case (r_cycle)
      A1:      dataOut = w_addr[3:0];
      A2:      dataOut = w_addr[7:4];
      A3:      dataOut = w_addr[11:8];
      default: dataOut = '0;
    endcase
  end

  assign cycle      = r_cycle;
  assign sync       = (r_cycle == X3);
  assign dataOe     = (r_cycle == A1) || (r_cycle == A2) || (r_cycle == A3);
  assign pc         = r_pc;
  assign opr        = r_opr;
  assign opa        = r_opa;
  assign operand2   = r_operand2;
  assign secondWord = r_second;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a ROM model answers the nibble address bus,
// each scenario checks outputs against hand-computed values.
module tb_fetch_sequencer;

  logic        clk;
  logic        rstN;
  logic        stepEn;
  logic [3:0]  dataIn;
  logic        ccIn;
  logic        iszNotZero;
  logic [7:0]  pairData;
  logic [2:0]  cycle;
  logic        sync;
  logic [3:0]  dataOut;
  logic        dataOe;
  logic [3:0]  opr;
  logic [3:0]  opa;
  logic        secondWord;
  logic [7:0]  operand2;
  logic [11:0] pc;

  logic [7:0]  rom [4096];
  logic [11:0] r_romAddr;
  logic [7:0]  w_romByte;

  int n_checks = 0;
  int n_errors = 0;

  fetch_sequencer dut (
    .clk        (clk),
    .rstN       (rstN),
    .stepEn     (stepEn),
    .dataIn     (dataIn),
    .ccIn       (ccIn),
    .iszNotZero (iszNotZero),
    .pairData   (pairData),
    .cycle      (cycle),
    .sync       (sync),
    .dataOut    (dataOut),
    .dataOe     (dataOe),
    .opr        (opr),
    .opa        (opa),
    .secondWord (secondWord),
    .operand2   (operand2),
    .pc         (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  // ROM latches the address nibbles it sees on the bus, as the real part would.
  always @(negedge clk) begin
    case (cycle)
      3'd0: r_romAddr[3:0]  <= dataOut;
      3'd1: r_romAddr[7:4]  <= dataOut;
      3'd2: r_romAddr[11:8] <= dataOut;
      default: ;
    endcase
  end

  always_comb begin
    w_romByte = rom[r_romAddr];
    dataIn    = (cycle == 3'd3) ? w_romByte[7:4] : w_romByte[3:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    rstN   = 1'b0;
    stepEn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstN   = 1'b1;
    stepEn = 1'b1;
  endtask

  // Called at the negedge of A1; returns at the negedge of the next A1.
  task automatic run_cycle(output logic [3:0] d0, output logic [3:0] d1,
                           output logic [3:0] d2, output int syncs);
    syncs = 0;
    d0 = '0; d1 = '0; d2 = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) d0 = dataOut;
      if (i == 1) d1 = dataOut;
      if (i == 2) d2 = dataOut;
      if (sync) syncs++;
      @(negedge clk);
    end
  endtask

  task automatic run_n(input int n);
    logic [3:0] a, b, c;
    int s;
    for (int i = 0; i < n; i++) run_cycle(a, b, c, s);
  endtask

  logic [3:0] d0, d1, d2;
  int         syncs;

  initial begin
    rstN = 1'b0; stepEn = 1'b0; ccIn = 1'b0; iszNotZero = 1'b0; pairData = 8'h00;
    clear_rom();

    // NOP stream from reset
    do_reset();
    check("rst_cycle", cycle, 0);
    check("rst_pc", pc, 0);
    check("rst_opr_opa", {opr, opa}, 0);
    check("rst_operand2", operand2, 0);
    check("rst_second", secondWord, 0);
    check("rst_sync", sync, 0);
    check("rst_dataOe", dataOe, 1);
    check("rst_dataOut", dataOut, 0);
    run_cycle(d0, d1, d2, syncs);
    check("nop1_addr", {d0, d1, d2}, 12'h000);
    check("nop1_sync", syncs, 1);
    run_cycle(d0, d1, d2, syncs);
    check("nop2_addr", {d0, d1, d2}, 12'h100);
    check("nop2_sync", syncs, 1);
    check("nop_pc", pc, 12'h002);

    // JUN 0x321
    clear_rom();
    rom[12'h000] = 8'h43; rom[12'h001] = 8'h21;
    do_reset();
    run_n(1);
    check("jun_second_set", secondWord, 1);
    check("jun_pc_mid", pc, 12'h001);
    run_n(1);
    check("jun_operand2", operand2, 8'h21);
    check("jun_opr_opa_held", {opr, opa}, 8'h43);
    check("jun_second_clr", secondWord, 0);
    check("jun_pc", pc, 12'h321);
    run_cycle(d0, d1, d2, syncs);
    check("jun_next_addr", {d0, d1, d2}, 12'h123);

    // JCN across a page boundary, taken then not taken
    clear_rom();
    rom[12'h000] = 8'h40; rom[12'h001] = 8'hFE;
    rom[12'h0FE] = 8'h1C; rom[12'h0FF] = 8'h80;
    ccIn = 1'b1;
    do_reset();
    run_n(4);
    check("jcn_taken_pc", pc, 12'h180);
    check("jcn_opr_opa", {opr, opa}, 8'h1C);
    ccIn = 1'b0;
    do_reset();
    run_n(4);
    check("jcn_not_taken_pc", pc, 12'h100);

    // JMS / BBL single level
    clear_rom();
    rom[12'h000] = 8'h40; rom[12'h001] = 8'h10;
    rom[12'h010] = 8'h52; rom[12'h011] = 8'h00;
    rom[12'h200] = 8'hC0;
    do_reset();
    run_n(2);
    check("jms_pre_pc", pc, 12'h010);
    run_n(2);
    check("jms_pc", pc, 12'h200);
    run_n(1);
    check("bbl_pc", pc, 12'h012);

    // Four nested JMS overflow the 3-level stack
    clear_rom();
    rom[12'h000] = 8'h50; rom[12'h001] = 8'h10;
    rom[12'h010] = 8'h50; rom[12'h011] = 8'h20;
    rom[12'h020] = 8'h50; rom[12'h021] = 8'h30;
    rom[12'h030] = 8'h50; rom[12'h031] = 8'h40;
    rom[12'h040] = 8'hC0; rom[12'h032] = 8'hC0;
    rom[12'h022] = 8'hC0; rom[12'h012] = 8'hC0;
    do_reset();
    run_n(8);
    check("nest_pc", pc, 12'h040);
    run_n(1);
    check("nest_ret1", pc, 12'h032);
    run_n(1);
    check("nest_ret2", pc, 12'h022);
    run_n(1);
    check("nest_ret3", pc, 12'h012);
    run_n(1);
    check("nest_ret4_overwritten", pc, 12'h032);

    // FIN, then JIN and ISZ
    clear_rom();
    rom[12'h000] = 8'h41; rom[12'h001] = 8'h05;
    rom[12'h105] = 8'h30; rom[12'h106] = 8'h31;
    rom[12'h17A] = 8'h9D;
    rom[12'h17B] = 8'h75; rom[12'h17C] = 8'h44;
    pairData = 8'h7A;
    iszNotZero = 1'b1;
    do_reset();
    run_n(2);
    check("fin_pre_pc", pc, 12'h105);
    run_n(1);
    check("fin_second_set", secondWord, 1);
    check("fin_pc_mid", pc, 12'h106);
    run_cycle(d0, d1, d2, syncs);
    check("fin_addr", {d0, d1, d2}, 12'hA71);
    check("fin_operand2", operand2, 8'h9D);
    check("fin_pc", pc, 12'h106);
    check("fin_second_clr", secondWord, 0);
    run_n(1);
    check("jin_pc", pc, 12'h17A);
    run_n(3);
    check("isz_pc", pc, 12'h144);

    // Stall in byte-2 M1, then asynchronous reset during X2
    clear_rom();
    rom[12'h000] = 8'h43; rom[12'h001] = 8'h21;
    iszNotZero = 1'b0;
    do_reset();
    run_n(1);
    repeat (3) @(negedge clk);
    check("stall_at_m1", cycle, 3);
    stepEn = 1'b0;
    repeat (5) @(negedge clk);
    check("stall_cycle", cycle, 3);
    check("stall_pc", pc, 12'h001);
    check("stall_second", secondWord, 1);
    check("stall_operand2", operand2, 8'h00);
    stepEn = 1'b1;
    repeat (3) @(negedge clk);
    check("resume_cycle", cycle, 6);
    check("resume_operand2", operand2, 8'h21);
    check("resume_pc", pc, 12'h002);
    #2 rstN = 1'b0;
    #1;
    check("arst_cycle", cycle, 0);
    check("arst_pc", pc, 0);
    check("arst_second", secondWord, 0);
    check("arst_regs", {opr, opa, operand2}, 0);
    check("arst_dataOe", dataOe, 1);
    @(negedge clk);
    rstN = 1'b1;
    run_cycle(d0, d1, d2, syncs);
    check("restart_addr", {d0, d1, d2}, 12'h000);
    check("restart_opr", opr, 4'h4);
    check("restart_second", secondWord, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
